// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store bus master with big-endian lane steering
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic                flush,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic                busy,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} stateT;

  stateT             state;
  stateT             nextState;
  logic [2:0]        opReg;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdataReg;
  logic              errReg;
  logic              cancel;
  logic [31:0]       respData;

  logic              accept;
  logic              reqMis;
  logic              isStore;
  logic              sizeByte;
  logic              sizeHalf;
  int                laneHi;
  int                laneLo;
  logic [LANES-1:0]  laneMask;
  logic [LANES-1:0]  beComb;
  logic [31:0]       lowWord;
  logic [31:0]       loadData;
  logic [DATA_W-1:0] wdataRep;

  assign accept = req_valid & req_ready & ~flush;

  // Alignment check on the incoming request; byte ops can never be misaligned
  always_comb begin
    reqMis = 1'b0;
    case (req_op)
      3'b010, 3'b011, 3'b110: reqMis = req_addr[0];
      3'b100, 3'b111:         reqMis = |req_addr[1:0];
      default:                reqMis = 1'b0;
    endcase
  end

  // Decode the registered op into size, direction and big-endian lane positions
  always_comb begin
    isStore  = opReg[2] & (opReg[1] | opReg[0]);
    sizeByte = (opReg == 3'b000) || (opReg == 3'b001) || (opReg == 3'b101);
    sizeHalf = (opReg == 3'b010) || (opReg == 3'b011) || (opReg == 3'b110);
    // offset k lives in lane LANES-1-k, so the first byte is the highest lane used
    laneHi   = LANES - 1 - int'(addrReg[OFFW-1:0]);
    laneMask = '0;
    if (sizeByte) begin
      laneLo      = laneHi;
      laneMask[0] = 1'b1;
    end else if (sizeHalf) begin
      laneLo        = laneHi - 1;
      laneMask[1:0] = 2'b11;
    end else begin
      laneLo        = laneHi - 3;
      laneMask[3:0] = 4'hF;
    end
    beComb  = laneMask << laneLo;
    lowWord = 32'(bus_rdata >> (8 * laneLo));
    case (opReg)
      3'b000:  loadData = {{24{lowWord[7]}}, lowWord[7:0]};
      3'b001:  loadData = {24'b0, lowWord[7:0]};
      3'b010:  loadData = {{16{lowWord[15]}}, lowWord[15:0]};
      3'b011:  loadData = {16'b0, lowWord[15:0]};
      default: loadData = lowWord;
    endcase
    if (sizeByte)      wdataRep = {LANES{wdataReg[7:0]}};
    else if (sizeHalf) wdataRep = {(LANES/2){wdataReg[15:0]}};
    else               wdataRep = {(DATA_W/32){wdataReg}};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: misaligned requests skip the bus and answer directly
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = reqMis ? RESP : BUS;
      BUS:     if (bus_ack) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture, cancel tracking and load-data capture on bus_ack
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg    <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
      errReg   <= 1'b0;
      cancel   <= 1'b0;
      respData <= '0;
    end else begin
      if (accept) begin
        opReg    <= req_op;
        addrReg  <= req_addr;
        wdataReg <= req_wdata;
        errReg   <= reqMis;
        cancel   <= 1'b0;
        respData <= '0;
      end
      // a flushed bus cycle still completes; only its response is dropped
      if (state == BUS && flush) cancel <= 1'b1;
      if (state == BUS && bus_ack) respData <= isStore ? 32'b0 : loadData;
      if (state == RESP) cancel <= 1'b0;
    end
  end

  // Outputs: bus signals only live in BUS, response only in an uncancelled RESP
  always_comb begin
    req_ready  = (state == IDLE) & ~rst;
    busy       = ~req_ready;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_be     = '0;
    bus_addr   = '0;
    bus_wdata  = '0;
    if (state == BUS) begin
      bus_req   = 1'b1;
      bus_we    = isStore;
      bus_be    = beComb;
      bus_addr  = addrReg & ALIGN_MASK;
      bus_wdata = wdataRep;
    end
    resp_valid = (state == RESP) & ~cancel & ~flush;
    resp_err   = resp_valid & errReg;
    resp_rdata = resp_valid ? respData : 32'b0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  reqOp = '0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        flush = 1'b0;

  logic        reqValid32 = 1'b0;
  logic        reqReady32, respValid32, respErr32, busy32, busReq32, busWe32;
  logic [31:0] respRdata32, busAddr32, busWdata32;
  logic [3:0]  busBe32;
  logic        ack32 = 1'b0;
  logic [31:0] rdata32 = '0;

  logic        reqValid64 = 1'b0;
  logic        reqReady64, respValid64, respErr64, busy64, busReq64, busWe64;
  logic [31:0] respRdata64, busAddr64;
  logic [63:0] busWdata64;
  logic [7:0]  busBe64;
  logic        ack64 = 1'b0;
  logic [63:0] rdata64 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .req_valid(reqValid32), .req_ready(reqReady32),
    .req_op(reqOp), .req_addr(reqAddr), .req_wdata(reqWdata), .flush(flush),
    .resp_valid(respValid32), .resp_rdata(respRdata32), .resp_err(respErr32),
    .busy(busy32), .bus_req(busReq32), .bus_we(busWe32), .bus_be(busBe32),
    .bus_addr(busAddr32), .bus_wdata(busWdata32), .bus_ack(ack32), .bus_rdata(rdata32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .req_valid(reqValid64), .req_ready(reqReady64),
    .req_op(reqOp), .req_addr(reqAddr), .req_wdata(reqWdata), .flush(1'b0),
    .resp_valid(respValid64), .resp_rdata(respRdata64), .resp_err(respErr64),
    .busy(busy64), .bus_req(busReq64), .bus_we(busWe64), .bus_be(busBe64),
    .bus_addr(busAddr64), .bus_wdata(busWdata64), .bus_ack(ack64), .bus_rdata(rdata64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on the 32-bit unit; cycle 0 is the accept cycle
  task automatic access32(
    input  logic [2:0]  op, input logic [31:0] addr, input logic [31:0] wd,
    input  int          waits, input logic [31:0] rd, input int flushAt,
    output int          respCyc, output logic [31:0] respD, output logic respE,
    output int          busyCyc, output int busCyc, output int readyCyc,
    output logic [3:0]  beSeen, output logic [31:0] addrSeen,
    output logic [31:0] wdSeen, output logic weSeen);
    respCyc = -1; respD = '0; respE = 1'b0; busyCyc = 0; busCyc = 0; readyCyc = -1;
    beSeen = '0; addrSeen = '0; wdSeen = '0; weSeen = 1'b0;
    @(negedge clk);
    reqValid32 = 1'b1; reqOp = op; reqAddr = addr; reqWdata = wd; flush = (flushAt == 0);
    #1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      reqValid32 = 1'b0; ack32 = 1'b0; flush = (flushAt == c);
      #1;
      if (busy32) busyCyc++;
      if (busReq32) begin
        busCyc++;
        beSeen = busBe32; addrSeen = busAddr32; wdSeen = busWdata32; weSeen = busWe32;
        if (busCyc == waits + 1) begin
          ack32 = 1'b1; rdata32 = rd;
        end
      end
      if (respValid32) begin
        respCyc = c; respD = respRdata32; respE = respErr32;
      end
      if (reqReady32) begin
        readyCyc = c;
        break;
      end
    end
    ack32 = 1'b0; flush = 1'b0;
  endtask

  int          rc, bsy, bc, rdy;
  logic [31:0] rdv, adv, wdv;
  logic        rev, wev;
  logic [3:0]  bev;
  logic [31:0] lbExp  [4] = '{32'hFFFFFF80, 32'h0000007F, 32'h00000001, 32'hFFFFFFFE};
  logic [31:0] lbuExp [4] = '{32'h00000080, 32'h0000007F, 32'h00000001, 32'h000000FE};

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(reqReady32), 64'h0);
    chk("rst_busy", 64'(busy32), 64'h1);
    chk("rst_busreq", 64'(busReq32), 64'h0);
    chk("rst_be", 64'(busBe32), 64'h0);
    chk("rst_resp", 64'({respValid32, respErr32, respRdata32}), 64'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_ready", 64'(reqReady32), 64'h1);

    // lw 0x100 with three wait cycles
    access32(3'b100, 32'h100, 32'h0, 3, 32'h8899AABB, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("lw_be", 64'(bev), 64'hF);
    chk("lw_addr", 64'(adv), 64'h100);
    chk("lw_we", 64'(wev), 64'h0);
    chk("lw_buscyc", 64'(bc), 64'd4);
    chk("lw_respcyc", 64'(rc), 64'd5);
    chk("lw_data", 64'(rdv), 64'h8899AABB);
    chk("lw_err", 64'(rev), 64'h0);
    chk("lw_busy", 64'(bsy), 64'd5);
    chk("lw_ready", 64'(rdy), 64'd6);

    // lb and lbu at every offset
    for (int k = 0; k < 4; k++) begin
      access32(3'b000, 32'h40 + 32'(k), 32'h0, 0, 32'h807F01FE, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
      chk($sformatf("lb_off%0d", k), 64'(rdv), 64'(lbExp[k]));
      chk($sformatf("lb_be%0d", k), 64'(bev), 64'(4'b1000 >> k));
      access32(3'b001, 32'h40 + 32'(k), 32'h0, 0, 32'h807F01FE, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
      chk($sformatf("lbu_off%0d", k), 64'(rdv), 64'(lbuExp[k]));
    end

    // halfword loads
    access32(3'b010, 32'h22, 32'h0, 1, 32'h1234F00D, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("lh_data", 64'(rdv), 64'hFFFFF00D);
    chk("lh_be", 64'(bev), 64'h3);
    access32(3'b011, 32'h20, 32'h0, 0, 32'hABCD0000, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("lhu_data", 64'(rdv), 64'h0000ABCD);

    // stores
    access32(3'b101, 32'h33, 32'h55AA77AB, 0, 32'hFFFFFFFF, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("sb_be", 64'(bev), 64'h1);
    chk("sb_wdata", 64'(wdv), 64'hABABABAB);
    chk("sb_we", 64'(wev), 64'h1);
    chk("sb_addr", 64'(adv), 64'h30);
    chk("sb_rdata", 64'(rdv), 64'h0);
    access32(3'b110, 32'h2, 32'hFFFF1234, 0, 32'h0, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("sh_be", 64'(bev), 64'h3);
    chk("sh_wdata", 64'(wdv), 64'h12341234);

    // misaligned accesses
    access32(3'b100, 32'h102, 32'h0, 0, 32'h0, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("mis_lw_respcyc", 64'(rc), 64'd1);
    chk("mis_lw_err", 64'(rev), 64'h1);
    chk("mis_lw_data", 64'(rdv), 64'h0);
    chk("mis_lw_bus", 64'(bc), 64'd0);
    chk("mis_lw_ready", 64'(rdy), 64'd2);
    access32(3'b010, 32'h103, 32'h0, 0, 32'h0, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("mis_lh_respcyc", 64'(rc), 64'd1);
    chk("mis_lh_err", 64'(rev), 64'h1);
    chk("mis_lh_bus", 64'(bc), 64'd0);

    // flush during BUS: bus runs to ack, response suppressed
    access32(3'b011, 32'h0, 32'h0, 2, 32'hFFFF0000, 1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("flbus_buscyc", 64'(bc), 64'd3);
    chk("flbus_resp", 64'(rc), 64'hFFFFFFFFFFFFFFFF);
    chk("flbus_ready", 64'(rdy), 64'd5);
    access32(3'b100, 32'h8, 32'h0, 0, 32'h01020304, -1, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("after_flush_data", 64'(rdv), 64'h01020304);

    // flush during RESP gates the strobe in the same cycle
    access32(3'b100, 32'h10, 32'h0, 0, 32'hCAFEF00D, 2, rc, rdv, rev, bsy, bc, rdy, bev, adv, wdv, wev);
    chk("flresp_resp", 64'(rc), 64'hFFFFFFFFFFFFFFFF);
    chk("flresp_ready", 64'(rdy), 64'd3);

    // flush in IDLE blocks acceptance
    @(negedge clk); reqValid32 = 1'b1; reqOp = 3'b100; reqAddr = 32'h0; flush = 1'b1; #1;
    @(negedge clk); reqValid32 = 1'b0; flush = 1'b0; #1;
    chk("flidle_busreq", 64'(busReq32), 64'h0);
    chk("flidle_ready", 64'(reqReady32), 64'h1);

    // reset while in BUS, with ack arriving during reset
    @(negedge clk); reqValid32 = 1'b1; reqOp = 3'b111; reqAddr = 32'h20; reqWdata = 32'hDEADBEEF; #1;
    @(negedge clk); reqValid32 = 1'b0; #1;
    chk("rbus_busreq", 64'(busReq32), 64'h1);
    @(negedge clk); rst = 1'b1; ack32 = 1'b1; #1;
    @(negedge clk); #1;
    chk("rbus_drop", 64'({busReq32, busWe32, busBe32}), 64'h0);
    chk("rbus_addr", 64'(busAddr32), 64'h0);
    chk("rbus_wdata", 64'(busWdata32), 64'h0);
    chk("rbus_resp", 64'(respValid32), 64'h0);
    @(negedge clk); rst = 1'b0; ack32 = 1'b0; #1;
    chk("rbus_noresp", 64'(respValid32), 64'h0);
    chk("rbus_ready", 64'(reqReady32), 64'h1);

    // 64-bit unit: sh 0x206
    @(negedge clk); reqValid64 = 1'b1; reqOp = 3'b110; reqAddr = 32'h206; reqWdata = 32'h1234; #1;
    @(negedge clk); reqValid64 = 1'b0; #1;
    chk("w64_busreq", 64'(busReq64), 64'h1);
    chk("w64_addr", 64'(busAddr64), 64'h200);
    chk("w64_be", 64'(busBe64), 64'h03);
    chk("w64_wdata", busWdata64, 64'h1234123412341234);
    chk("w64_we", 64'(busWe64), 64'h1);
    ack64 = 1'b1;
    @(negedge clk); ack64 = 1'b0; #1;
    chk("w64_resp", 64'({respValid64, respErr64}), 64'h2);
    chk("w64_rdata", 64'(respRdata64), 64'h0);

    // 64-bit unit: lw 0x204 reads the low four lanes
    @(negedge clk); reqValid64 = 1'b1; reqOp = 3'b100; reqAddr = 32'h204; #1;
    @(negedge clk); reqValid64 = 1'b0; #1;
    chk("r64_be", 64'(busBe64), 64'h0F);
    ack64 = 1'b1; rdata64 = 64'h1122334455667788;
    @(negedge clk); ack64 = 1'b0; #1;
    chk("r64_valid", 64'(respValid64), 64'h1);
    chk("r64_data", 64'(respRdata64), 64'h55667788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage load/store unit for the 5-stage MIPS pipeline. It replaces the combinational byte-lane/extension logic in the memory and writeback stages with a sequential bus master. The unit accepts one load or store at a time over a valid/ready handshake and drives a wait-state-capable data bus of DATA_W bits. It returns sign- or zero-extended load data, flags misaligned accesses without touching the bus, and supports pipeline flush of an in-flight access.

## Interface
- DATA_W, 32, data bus width; legal values 32 or 64; LANES = DATA_W/8
- ADDR_W, 32, byte address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request from memory stage
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 sb, 110 sh, 111 sw
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store source (rt value)
- flush  in  1  cancel the current/incoming access
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access (valid with resp_valid)
- busy  out  1  pipeline stall request; = ~req_ready
- bus_req  out  1  bus transaction request
- bus_we  out  1  1 = write
- bus_be  out  LANES  byte enables
- bus_addr  out  ADDR_W  req_addr with low log2(LANES) bits cleared
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_ack  in  1  transaction complete; bus_rdata valid this cycle
- bus_rdata  in  DATA_W  read data

## Operation
- States: IDLE, BUS, RESP. req_ready = (state==IDLE) & ~rst.
- Accept when req_valid & req_ready & ~flush; op, addr and wdata are registered.
- Alignment: lh/lhu/sh require addr[0]=0; lw/sw require addr[1:0]=00. Byte ops always align.
- IDLE: misaligned accept -> RESP with err=1, no bus activity; aligned accept -> BUS.
- BUS: bus_req=1 and all bus outputs held stable until bus_ack. On ack, capture bus_rdata -> RESP.
- RESP: resp_valid=1 for exactly one cycle, unless cancelled -> IDLE.
- Big-endian lanes: byte offset k = addr mod LANES maps to lane LANES-1-k (bits [8(LANES-1-k)+7 : 8(LANES-1-k)]).
- bus_be: byte = one lane; half = lanes for offsets k,k+1; word = four lanes at offsets k..k+3; loads use the same enables.
- bus_wdata: sb replicates wdata[7:0] LANES times; sh replicates [15:0] LANES/2 times; sw replicates [31:0] DATA_W/32 times.
- Load extraction from the captured lanes: lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- Flush in BUS: sets a cancel flag. The transaction still runs to bus_ack (no abort), then resp_valid is suppressed.
- Flush in RESP: resp_valid is gated to 0 in the same cycle. Flush in IDLE blocks acceptance.

## Timing
- Reset: state IDLE; resp_valid, resp_err, bus_req, bus_we = 0; bus_be, bus_addr, bus_wdata, resp_rdata = 0; cancel flag cleared.
- req_ready=0 during rst and 1 in the first cycle after.
- Reset mid-BUS: bus_req drops in the next cycle; a pending ack is ignored.
- Aligned access accepted at cycle 0: bus_req rises at cycle 1; ack at cycle k≥1; resp_valid at cycle k+1; req_ready again at k+2.
- Minimum aligned latency is 2 cycles; throughput is one access per 3 cycles.
- Misaligned access accepted at cycle 0: resp_valid with err=1 at cycle 1; req_ready at cycle 2.
- bus_ack outside BUS is ignored.

## Test plan
- DATA_W=32, lw addr 0x100, ack after 3 wait cycles, rdata 0x8899AABB -> bus_be=1111; resp_rdata=0x8899AABB at the cycle after ack; busy high for 5 cycles.
- DATA_W=32, lb at addr offsets 0..3 with rdata 0x80_7F_01_FE -> 0xFFFFFF80, 0x0000007F, 0x00000001, 0xFFFFFFFE.
  - Same stimulus as lbu -> 0x80, 0x7F, 0x01, 0xFE zero-extended.
- DATA_W=64, sh addr 0x206, wdata 0x1234 -> bus_addr=0x200, bus_be=0x03, bus_wdata=0x1234123412341234; resp_rdata=0.
- lw addr 0x102 -> resp_err=1 at cycle 1, bus_req never asserted.
  - lh addr 0x103 gives the same response.
- Flush asserted during BUS of lhu with rdata 0xFFFF0000 -> bus_req held until ack, resp_valid stays 0; a new request is accepted 2 cycles after ack.
- Reset asserted during BUS -> bus_req=0 the next cycle; all outputs 0; ack during reset produces no resp_valid.
